// File: rtl/booth_pkg.sv
// Shared constants for the radix-2 Booth multiplier controller and datapath.
package booth_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // mux_sel_Shift encodings: the controller drives {Q[0], Q-1} straight through
  localparam logic [1:0] SEL_NOP0 = 2'b00;
  localparam logic [1:0] SEL_ADD  = 2'b01;
  localparam logic [1:0] SEL_SUB  = 2'b10;
  localparam logic [1:0] SEL_NOP1 = 2'b11;

  // mux_sel_Mul encodings
  localparam logic MUL_LOAD = 1'b0;
  localparam logic MUL_ITER = 1'b1;

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: optional add/subtract of M into A, then
// an arithmetic right shift of {T, Q, Q-1} by one bit.
// Ports:
//   a, m       : WIDTH+1-bit accumulator and sign-extended multiplicand
//   q, qm1     : multiplier register and the Q-1 bit
//   sel        : 01 add M, 10 subtract M, 00/11 shift only
//   a_next_c, q_next_c, qm1_next_c : shifted results
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   m,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [1:0]       sel,
  output logic [WIDTH:0]   a_next_c,
  output logic [WIDTH-1:0] q_next_c,
  output logic             qm1_next_c
);

  logic [WIDTH:0] t;

  // Add/subtract modulo 2^(WIDTH+1), then shift with the guard bit replicated
  always_comb begin
    t = a;
    case (sel)
      SEL_ADD: t = a + m;
      SEL_SUB: t = a - m;
      default: t = a;
    endcase
    a_next_c   = {t[WIDTH], t[WIDTH:1]};
    q_next_c   = {t[0], q[WIDTH-1:1]};
    qm1_next_c = q[0];
  end

endmodule

// File: rtl/booth_datapath.sv
// Arithmetic datapath of the 16x16 sequential signed Booth multiplier.
// Holds A (with guard bit), M, Q, Q-1 and the iteration counter.
// Ports:
//   clk, rst      : clock and asynchronous active-low reset
//   clear         : controller idle/abort, zeroes the counter, operands hold
//   mux_sel_Mul   : 0 load operands, 1 perform one Booth iteration
//   mux_sel_Shift : 01 add M, 10 subtract M, 00/11 shift only
//   multiplicand, multiplier : signed operands, sampled on the load cycle
//   count_comp    : counter has reached WIDTH
//   Qo_Q1         : {Q[0], Q-1} for the controller's decode
//   product       : {A[WIDTH-1:0], Q}
module booth_datapath
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               mux_sel_Mul,
  input  logic [1:0]         mux_sel_Shift,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               count_comp,
  output logic [1:0]         Qo_Q1,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   a_step_c;
  logic [WIDTH-1:0] q_step_c;
  logic             qm1_step_c;
  logic             done_c;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a          (a_q),
    .m          (m_q),
    .q          (q_q),
    .qm1        (qm1_q),
    .sel        (mux_sel_Shift),
    .a_next_c   (a_step_c),
    .q_next_c   (q_step_c),
    .qm1_next_c (qm1_step_c)
  );

  assign done_c = (cnt_q == CNT_W'(WIDTH));

  // Register update: clear > load > iterate; saturates once WIDTH steps are done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (mux_sel_Mul == MUL_LOAD) begin
      a_q   <= '0;
      m_q   <= {multiplicand[WIDTH-1], multiplicand};
      q_q   <= multiplier;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else if (!done_c) begin
      a_q   <= a_step_c;
      q_q   <= q_step_c;
      qm1_q <= qm1_step_c;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Outputs decode registers only; no input reaches them combinationally
  assign count_comp = done_c;
  assign Qo_Q1      = {q_q[0], qm1_q};
  assign product    = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_booth_datapath.sv
// Directed bench for booth_datapath; the bench plays the controller role.
module tb_booth_datapath;

  localparam int unsigned W = 16;

  logic           clk;
  logic           rst;
  logic           clear;
  logic           mux_sel_Mul;
  logic [1:0]     mux_sel_Shift;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           count_comp;
  logic [1:0]     Qo_Q1;
  logic [2*W-1:0] product;

  int checks;
  int errors;

  booth_datapath #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .mux_sel_Mul   (mux_sel_Mul),
    .mux_sel_Shift (mux_sel_Shift),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .count_comp    (count_comp),
    .Qo_Q1         (Qo_Q1),
    .product       (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    clear         = 1'b0;
    mux_sel_Mul   = 1'b0;
    mux_sel_Shift = 2'bxx;
    multiplicand  = a;
    multiplier    = b;
    tick();
  endtask

  // One iteration, the select decoded from Qo_Q1 as the controller would
  task automatic iterate(input bit toggle);
    clear         = 1'b0;
    mux_sel_Mul   = 1'b1;
    mux_sel_Shift = Qo_Q1;
    if (toggle) begin
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
    end
    tick();
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [31:0] exp);
    load(a, b);
    for (int i = 0; i < 16; i++) begin
      iterate(1'b0);
      if (i == 14) check({tag, "_cc_early"}, 32'(count_comp), 32'd0);
    end
    check({tag, "_cc"}, 32'(count_comp), 32'd1);
    check({tag, "_prod"}, product, exp);
  endtask

  task automatic clear_cycle();
    clear         = 1'b1;
    mux_sel_Mul   = 1'bx;
    mux_sel_Shift = 2'bxx;
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    clear         = 1'b1;
    mux_sel_Mul   = 1'b0;
    mux_sel_Shift = 2'b00;
    multiplicand  = '0;
    multiplier    = '0;
    #12;
    check("rst_cc", 32'(count_comp), 32'd0);
    check("rst_qq", 32'(Qo_Q1), 32'd0);
    check("rst_prod", product, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 3 x 5: first decode pair after load is {Q[0]=1, Q-1=0}
    load(16'd3, 16'd5);
    check("l35_qq", 32'(Qo_Q1), 32'd2);
    for (int i = 0; i < 16; i++) begin
      iterate(1'b0);
      if (i == 14) check("m35_cc_early", 32'(count_comp), 32'd0);
    end
    check("m35_cc", 32'(count_comp), 32'd1);
    check("m35_prod", product, 32'h0000000F);

    // Extra iterate request at cnt == WIDTH must not step
    iterate(1'b0);
    check("sat_cc", 32'(count_comp), 32'd1);
    check("sat_prod", product, 32'h0000000F);

    clear_cycle();
    check("clr_cc", 32'(count_comp), 32'd0);
    check("clr_prod", product, 32'h0000000F);

    // Back-to-back: second load immediately follows the done cycle
    run("m_n7x3", 16'hFFF9, 16'd3, 32'hFFFFFFEB);
    run("m_3xn7", 16'd3, 16'hFFF9, 32'hFFFFFFEB);
    clear_cycle();
    run("m_minxmin", 16'h8000, 16'h8000, 32'h40000000);
    clear_cycle();
    run("m_minxmax", 16'h8000, 16'h7FFF, 32'hC0008000);
    clear_cycle();

    // Operands toggling outside the load cycle are ignored
    load(16'h1234, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      iterate(1'b1);
      check("tog_qq", 32'(Qo_Q1), 32'd0);
    end
    check("tog_cc", 32'(count_comp), 32'd1);
    check("tog_prod", product, 32'd0);
    clear_cycle();

    // Asynchronous reset in the middle of 100 x 100
    load(16'd100, 16'd100);
    for (int i = 0; i < 8; i++) iterate(1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cc", 32'(count_comp), 32'd0);
    check("arst_qq", 32'(Qo_Q1), 32'd0);
    check("arst_prod", product, 32'd0);
    clear = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    run("m100", 16'd100, 16'd100, 32'h00002710);

    // Idle with X selects holds the product
    for (int i = 0; i < 5; i++) begin
      clear_cycle();
      check("idle_cc", 32'(count_comp), 32'd0);
      check("idle_prod", product, 32'h00002710);
    end
    run("m2x2", 16'd2, 16'd2, 32'h00000004);
    clear_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
